// File: rtl/register_file_pkg.sv
// register_file_pkg: shared register indices and default data width for the i281 register file
package register_file_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;
endpackage

// File: rtl/register_file_read_port.sv
// regfile_read_port: 4:1 operand mux with optional same-cycle write forwarding
//   regs    in  4 x WIDTH  stored register contents, index 0=A .. 3=D
//   sel     in  2          register to read
//   wr_hit  in  1          a write commits on the coming edge (run & wr_en)
//   wr_sel  in  2          register being written
//   wr_data in  WIDTH      value being written
//   data    out WIDTH      selected operand
module regfile_read_port #(
  parameter int WIDTH = register_file_pkg::DEF_WIDTH,
  parameter bit BYPASS = 1'b0
) (
  input  logic [3:0][WIDTH-1:0] regs,
  input  logic [1:0]            sel,
  input  logic                  wr_hit,
  input  logic [1:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      data
);
  always_comb data = (BYPASS && wr_hit && wr_sel == sel) ? wr_data : regs[sel];
endmodule

// File: rtl/register_file.sv
// register_file: four-entry general-purpose register file (A..D) with two read ports and one write port
//   clock, reset (async, active-high), run (global gate)
//   wr_en/wr_sel/wr_data             write port, committed on rising edge when run & wr_en
//   rd_sel_left/rd_sel_right         read selects -> reginputleft/reginputright (combinational)
//   reg_a..reg_d                     raw contents for display
//   last_wr_sel                      index of most recently committed write
//   wr_strobe                        high the cycle after each committed write
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_sel_left,
  input  logic [1:0]       rd_sel_right,
  output logic [WIDTH-1:0] reginputleft,
  output logic [WIDTH-1:0] reginputright,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_c,
  output logic [WIDTH-1:0] reg_d,
  output logic [1:0]       last_wr_sel,
  output logic             wr_strobe
);
  logic [3:0][WIDTH-1:0] regs;
  logic commit;
  assign commit = run & wr_en;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs <= '0;
      last_wr_sel <= REG_A;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        regs[wr_sel] <= wr_data;
        last_wr_sel <= wr_sel;
      end
    end
  end
  assign reg_a = regs[REG_A];
  assign reg_b = regs[REG_B];
  assign reg_c = regs[REG_C];
  assign reg_d = regs[REG_D];
  regfile_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_left (
    .regs(regs), .sel(rd_sel_left), .wr_hit(commit), .wr_sel(wr_sel), .wr_data(wr_data), .data(reginputleft)
  );
  regfile_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_right (
    .regs(regs), .sel(rd_sel_right), .wr_hit(commit), .wr_sel(wr_sel), .wr_data(wr_data), .data(reginputright)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed check of register_file, both without (u0) and with (u1) write forwarding
module tb_register_file;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic wr_en = 1'b0;
  logic [1:0] wr_sel = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] rd_sel_left = 2'd0;
  logic [1:0] rd_sel_right = 2'd0;
  logic [7:0] l0, r0, a0, b0, c0, d0, l1, r1, a1, b1, c1, d1;
  logic [1:0] lw0, lw1;
  logic st0, st1;
  int checks = 0;
  int passes = 0;
  logic [7:0] mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [1:0] m_last = 2'd0;
  logic m_strobe = 1'b0;
  always #5 clock = ~clock;
  register_file #(.WIDTH(8), .BYPASS(1'b0)) u0 (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel_left(rd_sel_left), .rd_sel_right(rd_sel_right), .reginputleft(l0), .reginputright(r0),
    .reg_a(a0), .reg_b(b0), .reg_c(c0), .reg_d(d0), .last_wr_sel(lw0), .wr_strobe(st0)
  );
  register_file #(.WIDTH(8), .BYPASS(1'b1)) u1 (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel_left(rd_sel_left), .rd_sel_right(rd_sel_right), .reginputleft(l1), .reginputright(r1),
    .reg_a(a1), .reg_b(b1), .reg_c(c1), .reg_d(d1), .last_wr_sel(lw1), .wr_strobe(st1)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [7:0] model_read(input logic [1:0] sel, input bit fwd);
    return (fwd && run && wr_en && wr_sel == sel) ? wr_data : mem[sel];
  endfunction
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem = '{8'h00, 8'h00, 8'h00, 8'h00};
      m_last = 2'd0;
      m_strobe = 1'b0;
    end else begin
      m_strobe = run && wr_en;
      if (run && wr_en) begin
        mem[wr_sel] = wr_data;
        m_last = wr_sel;
      end
    end
  end
  always @(negedge clock) begin
    chk("m_reg_a", a0, mem[0]); chk("m_reg_b", b0, mem[1]);
    chk("m_reg_c", c0, mem[2]); chk("m_reg_d", d0, mem[3]);
    chk("m_bp_reg_a", a1, mem[0]); chk("m_bp_reg_b", b1, mem[1]);
    chk("m_bp_reg_c", c1, mem[2]); chk("m_bp_reg_d", d1, mem[3]);
    chk("m_left", l0, model_read(rd_sel_left, 1'b0));
    chk("m_right", r0, model_read(rd_sel_right, 1'b0));
    chk("m_bp_left", l1, model_read(rd_sel_left, 1'b1));
    chk("m_bp_right", r1, model_read(rd_sel_right, 1'b1));
    chk("m_last", {6'd0, lw0}, {6'd0, m_last});
    chk("m_bp_last", {6'd0, lw1}, {6'd0, m_last});
    chk("m_strobe", {7'd0, st0}, {7'd0, m_strobe});
    chk("m_bp_strobe", {7'd0, st1}, {7'd0, m_strobe});
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    run = 1'b1; wr_en = 1'b1; wr_sel = sel; wr_data = data;
  endtask
  initial begin
    step(); step();
    chk("rst_reg_c", c0, 8'h00);
    chk("rst_strobe", {7'd0, st0}, 8'h00);
    reset = 1'b0;
    wr(2'd2, 8'h5A); rd_sel_right = 2'd2;
    #1;
    chk("pre_right", r0, 8'h00);
    chk("pre_bp_right", r1, 8'h5A);
    step(); wr_en = 1'b0; #1;
    chk("wr_reg_c", c0, 8'h5A);
    chk("wr_right", r0, 8'h5A);
    chk("wr_strobe_hi", {7'd0, st0}, 8'h01);
    step();
    chk("wr_strobe_lo", {7'd0, st0}, 8'h00);
    run = 1'b0; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'hFF;
    step(); #1;
    chk("gate_reg_b", b0, 8'h00);
    chk("gate_strobe", {7'd0, st0}, 8'h00);
    chk("gate_last", {6'd0, lw0}, 8'h02);
    wr(2'd0, 8'h11); step();
    wr(2'd3, 8'h80); step();
    wr_en = 1'b0; rd_sel_left = 2'd3; rd_sel_right = 2'd0; #1;
    chk("dual_left", l0, 8'h80);
    chk("dual_right", r0, 8'h11);
    rd_sel_right = 2'd3; #1;
    chk("same_left", l0, 8'h80);
    chk("same_right", r0, 8'h80);
    step();
    wr(2'd0, 8'h22); rd_sel_left = 2'd0; #1;
    chk("rw_pre_left", l0, 8'h11);
    chk("rw_pre_bp_left", l1, 8'h22);
    step(); wr_en = 1'b0; #1;
    chk("rw_post_left", l0, 8'h22);
    chk("rw_post_bp_left", l1, 8'h22);
    step();
    wr(2'd1, 8'h01); step();
    chk("b2b_strobe1", {7'd0, st0}, 8'h01);
    chk("b2b_last1", {6'd0, lw0}, 8'h01);
    wr(2'd3, 8'h02); step();
    chk("b2b_strobe2", {7'd0, st0}, 8'h01);
    chk("b2b_last2", {6'd0, lw0}, 8'h03);
    chk("b2b_reg_d", d0, 8'h02);
    wr_en = 1'b0; step();
    chk("b2b_strobe_end", {7'd0, st0}, 8'h00);
    wr(2'd2, 8'hC3); rd_sel_left = 2'd1; rd_sel_right = 2'd3;
    step(); #2;
    reset = 1'b1; #1;
    chk("arst_reg_a", a0, 8'h00); chk("arst_reg_b", b0, 8'h00);
    chk("arst_reg_c", c0, 8'h00); chk("arst_reg_d", d0, 8'h00);
    chk("arst_left", l0, 8'h00); chk("arst_right", r0, 8'h00);
    chk("arst_strobe", {7'd0, st0}, 8'h00);
    chk("arst_last", {6'd0, lw0}, 8'h00);
    step();
    chk("arst_hold_reg_c", c0, 8'h00);
    chk("arst_hold_strobe", {7'd0, st1}, 8'h00);
    reset = 1'b0; wr_en = 1'b0;
    step(); step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
